mips_cpu_hilo_ctrl: RTL and testbench

Sequencing controller for the HI/LO multiply/divide unit (mips_cpu_alu_mult_div). It accepts decoded HI/LO-class requests from the decode/execute stage and drives the unit's op, operand and write inputs. It models multi-cycle MULT/DIV latency with an internal down-counter. It stalls the pipeline on any HI/LO access, or a new MULT/DIV, while a result is still pending.

---
 rtl/mips_cpu_hilo_pkg.sv | 35 +++
 rtl/mips_cpu_hilo_latency_ctr.sv | 29 ++
 rtl/mips_cpu_hilo_ctrl.sv | 97 +++++++++
 tb/tb_mips_cpu_hilo_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_hilo_pkg.sv
// HI/LO unit op encoding and sequencer state, shared with decode and the mult/div unit.
// No logic; constants, types and op-class helpers only.
// No flow control of its own.
package mips_cpu_hilo_pkg;

  localparam logic [2:0] OP_DIVU  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_MULT  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MFHI  = 3'b110;
  localparam logic [2:0] OP_MFLO  = 3'b111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Multi-cycle class: every op with the top bit clear.
  function automatic logic is_muldiv(input logic [2:0] op);
    return !op[2];
  endfunction

  // Divides are the multi-cycle ops with bit 0 clear.
  function automatic logic is_div(input logic [2:0] op);
    return !op[2] && !op[0];
  endfunction

  // MTHI/MTLO: the only ops that write HI/LO directly from IDLE.
  function automatic logic is_mt(input logic [2:0] op);
    return op[2] && !op[1];
  endfunction

endpackage

// File: rtl/mips_cpu_hilo_latency_ctr.sv
// Loadable down-counter with a zero flag, used to time MULT/DIV completion.
// Load takes effect on the next edge; zero is combinational from the count.
// No backpressure; it saturates at zero if decrement is held.
module mips_cpu_hilo_latency_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // Load wins over decrement; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mips_cpu_hilo_ctrl.sv
// Sequences HI/LO-class requests into the mult/div unit's op/operand/write inputs.
// MTHI/MTLO write the same cycle; MULT/DIV write LAT cycles after acceptance.
// Any request presented while a MULT/DIV is pending is stalled and must be held.
module mips_cpu_hilo_ctrl
  import mips_cpu_hilo_pkg::*;
#(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        stall,
  output logic        busy,
  output logic [2:0]  unit_op,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        unit_write
);

  localparam int MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  // Counter runs LAT-1 .. 0 inside BUSY, so BUSY spans exactly LAT cycles.
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LATENCY - 1);

  state_t        state;
  logic [2:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic          dz_q;
  logic          accept;
  logic          start;
  logic [CW-1:0] cnt;
  logic          cnt_zero;

  assign busy   = (state == BUSY);
  assign stall  = req_valid & busy;
  assign accept = req_valid & ~stall;
  // Acceptance implies IDLE, so start never re-arms a pending operation.
  assign start  = accept & is_muldiv(req_op);

  mips_cpu_hilo_latency_ctr #(
    .W (CW)
  ) u_lat_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .load_val (is_div(req_op) ? DIV_LOAD : MULT_LOAD),
    .dec      (busy & ~cnt_zero),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // IDLE/BUSY sequencing; operands are captured at start so decode may move on.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      dz_q  <= 1'b0;
    end else if (start) begin
      state <= BUSY;
      op_q  <= req_op;
      a_q   <= req_a;
      b_q   <= req_b;
      dz_q  <= is_div(req_op) && (req_b == '0);
    end else if (busy && cnt_zero) begin
      state <= IDLE;
    end
  end

  // Unit inputs follow the held operation while BUSY, the live request otherwise.
  always_comb begin
    unit_op    = req_op;
    unit_a     = req_a;
    unit_b     = req_b;
    unit_write = 1'b0;
    if (busy) begin
      unit_op    = op_q;
      unit_a     = a_q;
      unit_b     = b_q;
      // Divide-by-zero completes on schedule but leaves HI/LO untouched.
      unit_write = cnt_zero & ~dz_q;
    end else begin
      unit_write = accept & is_mt(req_op);
    end
    if (reset) begin
      unit_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_cpu_hilo_ctrl.sv
module tb_mips_cpu_hilo_ctrl;
  import mips_cpu_hilo_pkg::*;

  localparam int ML = 4;
  localparam int DL = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        stall, busy, unit_write;
  logic [2:0]  unit_op;
  logic [31:0] unit_a, unit_b;

  always #5 clk = ~clk;

  mips_cpu_hilo_ctrl #(.MULT_LATENCY(ML), .DIV_LATENCY(DL)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .stall      (stall),
    .busy       (busy),
    .unit_op    (unit_op),
    .unit_a     (unit_a),
    .unit_b     (unit_b),
    .unit_write (unit_write)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } wr_t;

  typedef struct {
    int          cyc;
    logic        busy;
    logic        stall;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cy_t;

  wr_t wrq[$];
  cy_t cyq[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  cyc = 0;

  // Reference model: a pending operation is just "accepted at acc_cyc, done at done_cyc".
  int          acc_cyc = -1;
  int          done_cyc = -1;
  logic [2:0]  p_op = '0;
  logic [31:0] p_a = '0;
  logic [31:0] p_b = '0;

  // Behavioural HI/LO unit fed by the controller's outputs.
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [63:0] unit_res(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
    longint sp;
    logic [63:0] up;
    case (op)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return 64'(sp);
      end
      OP_MULTU: begin
        up = {32'h0, a} * {32'h0, b};
        return up;
      end
      OP_DIV: begin
        if (b == 0) return {hi, lo};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
        return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      end
      OP_DIVU: begin
        if (b == 0) return {hi, lo};
        return {a % b, a / b};
      end
      OP_MTHI: return {a, lo};
      OP_MTLO: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      hi_m <= '0;
      lo_m <= '0;
    end else if (unit_write) begin
      {hi_m, lo_m} <= unit_res(unit_op, unit_a, unit_b, hi_m, lo_m);
    end
  end

  // One bench cycle: drive inputs, predict this cycle's outputs, update the model.
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic rst);
    cy_t e;
    wr_t w;
    logic bz;
    int lat;
    @(posedge clk);
    #1;
    cyc++;
    reset = rst;
    req_valid = v;
    req_op = op;
    req_a = a;
    req_b = b;
    bz = (done_cyc >= 0) && (cyc > acc_cyc) && (cyc <= done_cyc);
    e.cyc = cyc;
    e.busy = bz;
    e.stall = v & bz;
    e.op = bz ? p_op : op;
    e.a = bz ? p_a : a;
    e.b = bz ? p_b : b;
    cyq.push_back(e);
    if (rst) begin
      acc_cyc = -1;
      done_cyc = -1;
      while (wrq.size() > 0 && wrq[wrq.size()-1].cyc >= cyc) void'(wrq.pop_back());
    end else if (v && !bz) begin
      if (!op[2]) begin
        lat = op[0] ? ML : DL;
        acc_cyc = cyc;
        done_cyc = cyc + lat;
        p_op = op;
        p_a = a;
        p_b = b;
        if (op[0] || b != 0) begin
          w.cyc = cyc + lat; w.op = op; w.a = a; w.b = b;
          wrq.push_back(w);
        end
      end else if (op == OP_MTHI || op == OP_MTLO) begin
        w.cyc = cyc; w.op = op; w.a = a; w.b = b;
        wrq.push_back(w);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
  endtask

  // Monitor: compares every cycle's outputs and write strobes with the queued expectations.
  cy_t m_e;
  wr_t m_w;
  always @(negedge clk) begin
    if (cyq.size() > 0) begin
      m_e = cyq.pop_front();
      chk("busy", 64'(busy), 64'(m_e.busy));
      chk("stall", 64'(stall), 64'(m_e.stall));
      chk("unit_op", 64'(unit_op), 64'(m_e.op));
      chk("unit_a", 64'(unit_a), 64'(m_e.a));
      chk("unit_b", 64'(unit_b), 64'(m_e.b));
      while (wrq.size() > 0 && wrq[0].cyc < m_e.cyc) begin
        m_w = wrq.pop_front();
        chk("write_cycle", 64'(m_e.cyc), 64'(m_w.cyc));
      end
      if (unit_write) begin
        if (wrq.size() > 0 && wrq[0].cyc == m_e.cyc) begin
          m_w = wrq.pop_front();
          chk("write_op", 64'(unit_op), 64'(m_w.op));
          chk("write_a", 64'(unit_a), 64'(m_w.a));
          chk("write_b", 64'(unit_b), 64'(m_w.b));
        end else begin
          chk("unit_write_spurious", 64'(unit_write), 64'(0));
        end
      end else if (wrq.size() > 0 && wrq[0].cyc == m_e.cyc) begin
        m_w = wrq.pop_front();
        chk("unit_write_missing", 64'(unit_write), 64'(1));
      end
    end
  end

  logic        r_v;
  logic [2:0]  r_op;
  logic [31:0] r_b;
  logic        r_rst;

  initial begin
    repeat (2) @(posedge clk);
    // Reset values with a quiet request bus.
    step(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    idle(1);

    // MULT -2 * 3
    step(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(5);
    chk("mult_hi", 64'(hi_m), 64'(32'hFFFF_FFFF));
    chk("mult_lo", 64'(lo_m), 64'(32'hFFFF_FFFA));

    // DIVU 100 / 7 with MFLO held from the next cycle until accepted
    step(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b1, OP_MFLO, 32'h0, 32'h0, 1'b0);
    chk("divu_lo", 64'(lo_m), 64'(32'd14));
    chk("divu_hi", 64'(hi_m), 64'(32'd2));
    idle(1);

    // Divide by zero leaves HI/LO as written by MTHI/MTLO
    step(1'b1, OP_MTHI, 32'h1234, 32'h0, 1'b0);
    step(1'b1, OP_MTLO, 32'h5678, 32'h0, 1'b0);
    step(1'b1, OP_DIV, 32'd5, 32'd0, 1'b0);
    idle(17);
    chk("dz_hi", 64'(hi_m), 64'(32'h1234));
    chk("dz_lo", 64'(lo_m), 64'(32'h5678));

    // MTLO pass-through
    step(1'b1, OP_MTLO, 32'hDEAD_BEEF, 32'h0, 1'b0);
    idle(1);
    chk("mtlo_lo", 64'(lo_m), 64'(32'hDEAD_BEEF));

    // Back-to-back MULTU: second one presented in the completion cycle
    step(1'b1, OP_MULTU, 32'd3, 32'd5, 1'b0);
    idle(3);
    step(1'b1, OP_MULTU, 32'd7, 32'd9, 1'b0);
    step(1'b1, OP_MULTU, 32'd7, 32'd9, 1'b0);
    chk("b2b_first_lo", 64'(lo_m), 64'(32'd15));
    idle(5);
    chk("b2b_second_lo", 64'(lo_m), 64'(32'd63));
    chk("b2b_second_hi", 64'(hi_m), 64'(32'd0));

    // DIVU abandoned by a reset pulse in its third busy cycle
    step(1'b1, OP_DIVU, 32'd100, 32'd3, 1'b0);
    idle(2);
    step(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    idle(20);
    chk("abort_hi", 64'(hi_m), 64'(32'h0));
    chk("abort_lo", 64'(lo_m), 64'(32'h0));

    // Randomised traffic, including divide-by-zero and occasional resets
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_v = !r_rst && ($urandom_range(0, 9) < 7);
      r_op = 3'($urandom_range(0, 7));
      r_b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      step(r_v, r_op, $urandom, r_b, r_rst);
    end
    idle(DL + 2);

    @(negedge clk);
    #1;
    chk("write_queue_drained", 64'(wrq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
